// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the
// {PSEL,PENABLE} phase constants used by requester and completer blocks.
package apb_pkg;

   localparam int ADDR_WIDTH_DEF = 10;
   localparam int DATA_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_state_e;

   // Bus phase as seen on {PSEL, PENABLE}
   localparam logic [1:0] PHASE_IDLE   = 2'b00;
   localparam logic [1:0] PHASE_SETUP  = 2'b10;
   localparam logic [1:0] PHASE_ACCESS = 2'b11;

endpackage

// File: rtl/apb_master_if.sv
// Bundle of the command stream, response stream and APB bus of the requester.
// The master modport is the requester side, the slave modport its environment.
interface apb_master_if
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_slverr;

   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_slverr,
      input  rsp_ready,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_slverr,
      output rsp_ready,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_master_timer.sv
// ACCESS-phase wait counter. Cleared before ACCESS entry, counts wait cycles,
// and flags expire on the cycle whose increment would reach LIMIT.
module apb_master_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic expire
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   // Wait-cycle counter
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expire = inc && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time is turned into SETUP/ACCESS phases and
// the result is returned on a held response stream.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
`ifdef APB_MASTER_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 16
`endif
) (
   input  logic          PCLK,
   input  logic          PRESET,
   apb_master_if.master  bus
);

   apb_state_e            state;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_slverr;
   logic                  cmd_ready;
   logic                  accept;

   // Reset forces cmd_ready low even before the registered state settles
   assign cmd_ready = !PRESET && (state == IDLE) && (!rsp_valid || bus.rsp_ready);
   assign accept    = bus.cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
   logic timeout_expire;

   apb_master_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (PCLK),
      .rst    (PRESET),
      .clear  (state == SETUP),
      .inc    ((state == ACCESS) && !bus.PREADY),
      .expire (timeout_expire)
   );
`endif

   // Transfer FSM with registered APB and response outputs
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state           <= IDLE;
         {psel, penable} <= PHASE_IDLE;
         pwrite          <= 1'b0;
         paddr           <= '0;
         pwdata          <= '0;
         rsp_valid       <= 1'b0;
         rsp_rdata       <= '0;
         rsp_slverr      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rsp_valid && bus.rsp_ready) begin
                  rsp_valid <= 1'b0;
               end
               if (accept) begin
                  paddr           <= bus.cmd_addr;
                  pwrite          <= bus.cmd_write;
                  pwdata          <= bus.cmd_write ? bus.cmd_wdata : '0;
                  {psel, penable} <= PHASE_SETUP;
                  state           <= SETUP;
               end
            end
            SETUP: begin
               {psel, penable} <= PHASE_ACCESS;
               state           <= ACCESS;
            end
            ACCESS: begin
               // PREADY wins over a timeout landing on the same edge
               if (bus.PREADY) begin
                  {psel, penable} <= PHASE_IDLE;
                  state           <= IDLE;
                  rsp_valid       <= 1'b1;
                  rsp_rdata       <= pwrite ? '0 : bus.PRDATA;
                  rsp_slverr      <= bus.PSLVERR;
               end
`ifdef APB_MASTER_TIMEOUT_EN
               else if (timeout_expire) begin
                  {psel, penable} <= PHASE_IDLE;
                  state           <= IDLE;
                  rsp_valid       <= 1'b1;
                  rsp_rdata       <= '0;
                  rsp_slverr      <= 1'b1;
               end
`endif
            end
            default: begin
               {psel, penable} <= PHASE_IDLE;
               state           <= IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = cmd_ready;
   assign bus.rsp_valid  = rsp_valid;
   assign bus.rsp_rdata  = rsp_rdata;
   assign bus.rsp_slverr = rsp_slverr;
   assign bus.PSEL       = psel;
   assign bus.PENABLE    = penable;
   assign bus.PWRITE     = pwrite;
   assign bus.PADDR      = paddr;
   assign bus.PWDATA     = pwdata;

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester (bridge) that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response stream.
- Sits between an internal controller (CPU-side sequencer, DMA) and APB completer peripherals such as the memory/UART slave on PCLK.
- One outstanding transfer at a time.

Parameters:
- ADDR_WIDTH, 10, width of PADDR and cmd_addr.
- DATA_WIDTH, 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only with the optional feature.

Ports:
- PCLK  in  1  sole clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_slverr  out  1  completer error.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  completer ready.
- PSLVERR  in  1  completer error.

Behaviour:
- Reset: one clock and one reset; PRESET is synchronous and active-high, sampled on the PCLK rising edge. While PRESET is high, all outputs are 0, including cmd_ready, and state is IDLE.
- State machine: IDLE, SETUP, ACCESS. All APB outputs are registered.
- cmd_ready = (state == IDLE) && (!rsp_valid || rsp_ready).
- Accept (edge with cmd_valid && cmd_ready):
  - Latch the command into PADDR, PWRITE and PWDATA. PWDATA = cmd_wdata on writes, 0 on reads.
  - Next cycle enter SETUP with PSEL=1, PENABLE=0.
- SETUP -> ACCESS unconditionally after 1 cycle; PSEL=1, PENABLE=1.
- ACCESS:
  - Remain while PREADY=0.
  - On an edge with PREADY=1, return to IDLE and drop PSEL and PENABLE to 0.
  - Load rsp_rdata = PWRITE ? 0 : PRDATA.
  - Load rsp_slverr = PSLVERR; PSLVERR is sampled only with PREADY=1.
  - Set rsp_valid=1.
- PADDR, PWRITE and PWDATA are stable from SETUP through the completing ACCESS edge. They hold their last value in IDLE.
- Latency: command accepted at edge T gives SETUP in T+1, ACCESS in T+2, and rsp_valid no earlier than T+3. Each PREADY wait cycle adds 1.
- rsp_valid, rsp_rdata and rsp_slverr hold until rsp_ready. rsp_valid clears on the handshake edge.
- Simultaneous events: a response handshake and a new command accept may occur on the same edge. That gives a back-to-back rate of 1 transfer per 3 cycles with zero-wait completers.
- PREADY arriving during IDLE or SETUP is ignored.
- Reset mid-transfer (any state): next cycle is IDLE, PSEL=0, PENABLE=0. The in-flight transfer is dropped, no response is produced, and any pending response is discarded.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on ACCESS entry and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: IDLE next cycle, PSEL and PENABLE drop.
  - The response is rsp_valid=1, rsp_slverr=1, rsp_rdata=0.
  - PREADY on the same edge as the limit wins: normal completion.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Decomposition:
- Shared package apb_pkg holds:
  - state encoding: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10;
  - default ADDR_WIDTH and DATA_WIDTH constants;
  - the APB phase constants also used by apb_slave-side blocks.
- One natural sub-module: apb_master_timer, the wait counter with clear, increment and expire outputs. It is instantiated only under APB_MASTER_TIMEOUT_EN.

Test Plan:
- Write addr 0x001 data 0xDEADBEEF against a completer giving PREADY after 1 wait cycle -> PSEL/PENABLE sequence 10, 11, 11, then 00; rsp_valid at T+4; rsp_slverr=0; rsp_rdata=0.
- Read addr 0x001 following that write -> PWDATA=0 during the transfer; rsp_rdata=0xDEADBEEF; rsp_slverr=0.
- Write addr 0x002 to a completer flagging error for address index >= 2 -> rsp_slverr=1.
- rsp_ready held low 5 cycles with cmd_valid high -> rsp fields stable, cmd_ready=0, PSEL=0 throughout. On the rsp_ready edge the next command is accepted on that same edge.
- PRESET pulsed for 1 cycle during ACCESS of a read -> PSEL=0 and PENABLE=0 the next cycle; no rsp_valid ever produced for that transfer.
- PREADY held low: with APB_MASTER_TIMEOUT_EN, after 16 ACCESS cycles rsp_slverr=1 and rsp_rdata=0; without it, PSEL=1 and PENABLE=1 are still high at cycle 100.
